// File: rtl/nios2_qsys_0_mul_seq.sv
// Sequential 32x32 multiply built around one registered 16x16 unsigned multiplier.
// Define NIOS2_MUL_SEQ_MULX_EN to add the MULXUU/MULXSU/MULXSS high-word ops.
module nios2_qsys_0_mul_seq (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshake: a request is taken on an edge with req_valid && req_ready; a
  // response is retired on an edge with rsp_valid && rsp_ready. rsp_valid and
  // rsp_result hold steady until retired; req_ready is high only in IDLE.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_FINAL = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] a;
  logic [31:0] b;
  logic [63:0] acc;
  logic [1:0]  idx;
  logic [31:0] prod;
  logic [5:0]  prod_sh;

  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic [5:0]  issue_sh;
  logic [63:0] acc_sum;
  logic [1:0]  last_idx;
  logic [31:0] result_sel;

  // idx bit 0 picks the half of a, bit 1 the half of b: p0..p3 in order.
  assign mul_a    = idx[0] ? a[31:16] : a[15:0];
  assign mul_b    = idx[1] ? b[31:16] : b[15:0];
  assign issue_sh = (idx == 2'd0) ? 6'd0 : ((idx == 2'd3) ? 6'd32 : 6'd16);
  assign acc_sum  = acc + ({32'd0, prod} << prod_sh);

`ifdef NIOS2_MUL_SEQ_MULX_EN
  logic [1:0]  op;
  logic [31:0] hi_word;
  logic [31:0] corr_a;
  logic [31:0] corr_b;

  assign last_idx = (op == 2'd0) ? 2'd2 : 2'd3;
  assign hi_word  = acc_sum[63:32];
  // Signed high words come from the unsigned product minus the sign corrections.
  assign corr_a   = a[31] ? b : 32'd0;
  assign corr_b   = b[31] ? a : 32'd0;

  always_comb begin
    result_sel = acc_sum[31:0];
    case (op)
      2'd0: result_sel = acc_sum[31:0];
      2'd1: result_sel = hi_word;
      2'd2: result_sel = hi_word - corr_a;
      2'd3: result_sel = hi_word - corr_a - corr_b;
      default: result_sel = acc_sum[31:0];
    endcase
  end
`else
  logic unused_op;

  assign unused_op  = ^req_op;
  assign last_idx   = 2'd2;
  assign result_sel = acc_sum[31:0];
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      a          <= 32'd0;
      b          <= 32'd0;
      acc        <= 64'd0;
      idx        <= 2'd0;
      prod       <= 32'd0;
      prod_sh    <= 6'd0;
      rsp_valid  <= 1'b0;
      rsp_result <= 32'd0;
`ifdef NIOS2_MUL_SEQ_MULX_EN
      op         <= 2'd0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            a       <= req_src1;
            b       <= req_src2;
            acc     <= 64'd0;
            idx     <= 2'd0;
            prod    <= 32'd0;
            prod_sh <= 6'd0;
`ifdef NIOS2_MUL_SEQ_MULX_EN
            op      <= req_op;
`endif
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Fold in the product issued last cycle while issuing the next one.
          acc     <= acc_sum;
          prod    <= {16'd0, mul_a} * {16'd0, mul_b};
          prod_sh <= issue_sh;
          idx     <= idx + 2'd1;
          if (idx == last_idx) begin
            state <= S_FINAL;
          end
        end
        S_FINAL: begin
          acc        <= acc_sum;
          rsp_result <= result_sel;
          rsp_valid  <= 1'b1;
          state      <= S_DONE;
        end
        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_nios2_qsys_0_mul_seq.sv
// Bench for nios2_qsys_0_mul_seq: vector table, random ops against a 64-bit
// arithmetic model, backpressure, mid-operation reset and back-to-back requests.
module tb_nios2_qsys_0_mul_seq;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic        busy;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  nios2_qsys_0_mul_seq dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_src1   (req_src1),
    .req_src2   (req_src2),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_x;
    logic [31:0] exp_m;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on sign- or zero-extended operands.
  function automatic logic [31:0] model(input logic [1:0] op_in, input logic [31:0] a, input logic [31:0] b);
    logic [1:0]  op_eff;
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
`ifdef NIOS2_MUL_SEQ_MULX_EN
    op_eff = op_in;
`else
    op_eff = 2'd0;
    if (op_in != 2'd0) op_eff = 2'd0;
`endif
    ea = {32'd0, a};
    eb = {32'd0, b};
    if (op_eff >= 2'd2) ea = {{32{a[31]}}, a};
    if (op_eff == 2'd3) eb = {{32{b[31]}}, b};
    p = ea * eb;
    return (op_eff == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic int exp_lat(input logic [1:0] op_in);
`ifdef NIOS2_MUL_SEQ_MULX_EN
    return (op_in == 2'd0) ? 4 : 5;
`else
    return (op_in == 2'd0) ? 4 : 4;
`endif
  endfunction

  // Driver: one full transaction, sampled at posedge+1.
  task automatic run_txn(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int hold,
                         input bit toggle);
    int w;
    int lat;
    logic [31:0] held;
    w = 0;
    while (!req_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    if (!req_ready) begin
      n_vec++; n_err++;
      $display("FAIL %s_ready: got req_ready 0 after %0d cycles, expected 1", name, w);
      return;
    end
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_src1  = $urandom;
    req_src2  = $urandom;
    req_op    = 2'($urandom_range(0, 3));
    check({name, "_busy"}, {31'd0, busy}, 32'd1);
    lat = 0;
    while (!rsp_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_lat"}, lat, exp_lat(op));
    if (!rsp_valid) begin
      void'(exp_q.pop_front());
      return;
    end
    held = rsp_result;
    check({name, "_result"}, rsp_result, exp_q.pop_front());
    for (int i = 0; i < hold; i++) begin
      if (toggle) begin
        req_valid = 1'($urandom_range(0, 1));
        req_op    = 2'($urandom_range(0, 3));
        req_src1  = $urandom;
        req_src2  = $urandom;
      end
      @(posedge clk); #1;
      check({name, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
      check({name, "_hold_result"}, rsp_result, held);
      if (toggle) check({name, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({name, "_retired"}, {31'd0, rsp_valid}, 32'd0);
    check({name, "_ready_back"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    int accept_cyc[3];
    int accepted;
    int got;
    bit rr;
    bit stray;
    logic [31:0] ops_a[3];
    logic [31:0] ops_b[3];

    //            op     a              b              exp MULX      exp MUL-only
    tbl[0] = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
    tbl[1] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    tbl[2] = '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    tbl[3] = '{2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
    tbl[4] = '{2'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    tbl[5] = '{2'd2, 32'h0000_0003, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000};
    tbl[6] = '{2'd0, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 32'h0000_002A};
    tbl[7] = '{2'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    tbl[8] = '{2'd3, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    tbl[9] = '{2'd2, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE};

    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'd0;
    req_src1  = 32'd0;
    req_src2  = 32'd0;
    rsp_ready = 1'b0;
    #12;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
`ifdef NIOS2_MUL_SEQ_MULX_EN
      run_txn($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp_x, 0, 1'b0);
`else
      run_txn($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp_m, 0, 1'b0);
`endif
    end

    // Randomized ops, operands and response backpressure
    for (int i = 0; i < 40; i++) begin
      r_op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0: r_a = 32'h8000_0000;
        1: r_a = 32'hFFFF_FFFF;
        default: r_a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: r_b = 32'h0000_0000;
        1: r_b = 32'h8000_0001;
        default: r_b = $urandom;
      endcase
      run_txn($sformatf("rnd%0d", i), r_op, r_a, r_b, model(r_op, r_a, r_b),
              $urandom_range(0, 3), 1'b0);
    end

    // Long backpressure with inputs toggling while busy
    run_txn("bp", 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            model(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 10, 1'b1);
    @(posedge clk); #1;
    check("bp_single_handshake", {31'd0, busy}, 32'd0);

    // Reset at E2 of a MULXSS
    req_valid = 1'b1;
    req_op    = 2'd3;
    req_src1  = 32'h1234_5678;
    req_src2  = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("mid_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_rsp_result", rsp_result, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) stray = 1'b1;
    end
    check("mid_rst_no_rsp", {31'd0, stray}, 32'd0);
    run_txn("post_rst", 2'd0, 32'd7, 32'd6, 32'h0000_002A, 0, 1'b0);

    // Back-to-back MULs with req_valid held high
    ops_a[0] = 32'd7;         ops_b[0] = 32'd6;
    ops_a[1] = 32'hFFFF_FFFF; ops_b[1] = 32'hFFFF_FFFF;
    ops_a[2] = 32'd123;       ops_b[2] = 32'd1000;
    rsp_ready = 1'b1;
    req_op    = 2'd0;
    req_src1  = ops_a[0];
    req_src2  = ops_b[0];
    req_valid = 1'b1;
    exp_q.push_back(model(2'd0, ops_a[0], ops_b[0]));
    accepted = 0;
    got = 0;
    for (int cyc = 0; cyc < 60 && got < 3; cyc++) begin
      rr = req_ready;
      @(posedge clk); #1;
      if (rr && req_valid) begin
        accept_cyc[accepted] = cyc;
        accepted++;
        if (accepted < 3) begin
          req_src1 = ops_a[accepted];
          req_src2 = ops_b[accepted];
          exp_q.push_back(model(2'd0, ops_a[accepted], ops_b[accepted]));
        end else begin
          req_valid = 1'b0;
        end
      end
      if (rsp_valid) begin
        check($sformatf("b2b_result%0d", got), rsp_result, exp_q.pop_front());
        got++;
      end
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    check("b2b_count", got, 32'd3);
    check("b2b_accepts", accepted, 32'd3);
    if (accepted == 3) begin
      check("b2b_gap01", accept_cyc[1] - accept_cyc[0], 32'd6);
      check("b2b_gap12", accept_cyc[2] - accept_cyc[1], 32'd6);
    end
    check("queue_empty", exp_q.size(), 32'd0);

    // Report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
